// File: rtl/multichannel_enable_delay.sv
// multichannel_enable_delay: per-channel turn-on / turn-off delay with short-pulse and short-gap suppression.
// Latency: delayed_enable_o follows enable_i after on_delay/off_delay cycles (delay 0 = one register stage).
// No backpressure: every channel is evaluated independently on every clock edge.
module multichannel_enable_delay #(
   parameter int N_CHANNELS    = 4,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [N_CHANNELS-1:0]               enable_i,
   input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] on_delay_i,
   input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] off_delay_i,
   output logic [N_CHANNELS-1:0]               delayed_enable_o,
   output logic [N_CHANNELS-1:0]               busy_o
);

   // Encoding chosen so bit 1 is the delayed enable and bit 0 is busy:
   // both outputs are then plain flop outputs with no decode glitches.
   typedef enum logic [1:0] {
      ST_OFF       = 2'b00,
      ST_ON_COUNT  = 2'b01,
      ST_ON        = 2'b10,
      ST_OFF_COUNT = 2'b11
   } state_e;

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
      state_e                   state_q;
      state_e                   state_d;
      logic [COUNTER_WIDTH-1:0] cnt_q;
      logic [COUNTER_WIDTH-1:0] cnt_d;
      logic [COUNTER_WIDTH-1:0] on_dly;
      logic [COUNTER_WIDTH-1:0] off_dly;
      logic                     de_c;
      logic                     busy_c;

      assign on_dly  = on_delay_i[g*COUNTER_WIDTH +: COUNTER_WIDTH];
      assign off_dly = off_delay_i[g*COUNTER_WIDTH +: COUNTER_WIDTH];

      // State and counter registers; reset abandons any count in progress.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // Next state: the enable level (cancellation) always wins over count expiry.
      // Delays are captured only when leaving OFF/ON; later changes do not disturb a count.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            ST_OFF: begin
               if (enable_i[g]) begin
                  if (on_dly == '0) begin
                     state_d = ST_ON;
                  end else begin
                     state_d = ST_ON_COUNT;
                     cnt_d   = on_dly - COUNTER_WIDTH'(1);
                  end
               end
            end
            ST_ON_COUNT: begin
               if (!enable_i[g]) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  state_d = ST_ON;
               end else begin
                  cnt_d = cnt_q - COUNTER_WIDTH'(1);
               end
            end
            ST_ON: begin
               if (!enable_i[g]) begin
                  if (off_dly == '0) begin
                     state_d = ST_OFF;
                  end else begin
                     state_d = ST_OFF_COUNT;
                     cnt_d   = off_dly - COUNTER_WIDTH'(1);
                  end
               end
            end
            ST_OFF_COUNT: begin
               if (enable_i[g]) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  state_d = ST_OFF;
               end else begin
                  cnt_d = cnt_q - COUNTER_WIDTH'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs decoded from the registered state only.
      always_comb begin
         de_c   = (state_q == ST_ON)       || (state_q == ST_OFF_COUNT);
         busy_c = (state_q == ST_ON_COUNT) || (state_q == ST_OFF_COUNT);
      end

      assign delayed_enable_o[g] = de_c;
      assign busy_o[g]           = busy_c;
   end

endmodule

// File: tb/tb_multichannel_enable_delay.sv
// Testbench for multichannel_enable_delay: directed sequences plus a random phase,
// with a per-channel deadline-based reference model feeding an expected-value queue.
// Each clock edge pushes the predicted {delayed_enable, busy}, which is popped and compared after the edge.
module tb_multichannel_enable_delay;
   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   en;
   logic [N*W-1:0] on_d;
   logic [N*W-1:0] off_d;
   logic [N-1:0]   de;
   logic [N-1:0]   busy;

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   string phase  = "init";

   logic [N-1:0]   m_de;
   logic [N-1:0]   m_busy;
   int             m_deadline [N];
   logic [N-1:0]   prev_de;
   int             rise_edge [N];
   int             fall_edge [N];
   int             busy_cnt  [N];
   logic [2*N-1:0] sb_q [$];

   int onv  [N] = '{0, 1, 7, 300};
   int offv [N] = '{0, 2, 7, 65535};
   int k;

   multichannel_enable_delay #(.N_CHANNELS(N), .COUNTER_WIDTH(W)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .enable_i         (en),
      .on_delay_i       (on_d),
      .off_delay_i      (off_d),
      .delayed_enable_o (de),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, cyc);
      end
   endtask

   function automatic int dly(input logic [N*W-1:0] v, input int ch);
      return int'(v[ch*W +: W]);
   endfunction

   // Reference: a count started at edge c with delay D completes at edge c+D.
   task automatic model_edge();
      if (rst) begin
         m_de   = '0;
         m_busy = '0;
         return;
      end
      for (int ch = 0; ch < N; ch++) begin
         case ({m_de[ch], m_busy[ch]})
            2'b00: if (en[ch]) begin
               if (dly(on_d, ch) == 0) m_de[ch] = 1'b1;
               else begin
                  m_busy[ch]     = 1'b1;
                  m_deadline[ch] = cyc + dly(on_d, ch);
               end
            end
            2'b01: if (!en[ch]) m_busy[ch] = 1'b0;
                   else if (cyc == m_deadline[ch]) begin
                      m_busy[ch] = 1'b0;
                      m_de[ch]   = 1'b1;
                   end
            2'b10: if (!en[ch]) begin
               if (dly(off_d, ch) == 0) m_de[ch] = 1'b0;
               else begin
                  m_busy[ch]     = 1'b1;
                  m_deadline[ch] = cyc + dly(off_d, ch);
               end
            end
            default: if (en[ch]) m_busy[ch] = 1'b0;
                     else if (cyc == m_deadline[ch]) begin
                        m_busy[ch] = 1'b0;
                        m_de[ch]   = 1'b0;
                     end
         endcase
      end
   endtask

   task automatic step();
      logic [2*N-1:0] obs_v;
      logic [2*N-1:0] exp_v;
      cyc++;
      model_edge();
      sb_q.push_back({m_de, m_busy});
      @(posedge clk);
      #1;
      obs_v = {de, busy};
      exp_v = sb_q.pop_front();
      check(phase, 32'(obs_v), 32'(exp_v));
      for (int ch = 0; ch < N; ch++) begin
         if (de[ch] && !prev_de[ch]) rise_edge[ch] = cyc;
         if (!de[ch] && prev_de[ch]) fall_edge[ch] = cyc;
         if (busy[ch]) busy_cnt[ch]++;
      end
      prev_de = de;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_marks();
      for (int ch = 0; ch < N; ch++) begin
         rise_edge[ch] = -1;
         fall_edge[ch] = -1;
         busy_cnt[ch]  = 0;
      end
   endtask

   initial begin
      rst     = 1'b1;
      en      = '0;
      on_d    = '0;
      off_d   = '0;
      prev_de = '0;
      m_de    = '0;
      m_busy  = '0;
      for (int ch = 0; ch < N; ch++) m_deadline[ch] = 0;
      clear_marks();

      // Reset state before any clock edge
      #1;
      check("reset_de", 32'(de), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      phase = "reset_hold";
      run(2);
      rst = 1'b0;

      // Asynchronous reset while channel 0 is counting toward turn-on
      phase = "async_rst";
      on_d[0 +: W] = W'(5);
      en[0] = 1'b1;
      run(2);
      check("ch0_busy_before_rst", 32'(busy[0]), 32'(1));
      #2 rst = 1'b1;
      #1;
      check("async_rst_de", 32'(de), 32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      run(1);
      rst = 1'b0;
      clear_marks();
      k = cyc + 1;
      run(7);
      check("rst_release_rise", rise_edge[0] - k, 5);
      en[0] = 1'b0;
      run(2);

      // Turn-on / turn-off latency on all channels, including the maximum delay
      phase = "on_off";
      for (int ch = 0; ch < N; ch++) begin
         on_d[ch*W +: W]  = W'(onv[ch]);
         off_d[ch*W +: W] = W'(offv[ch]);
      end
      clear_marks();
      en = '1;
      k  = cyc + 1;
      run(305);
      for (int ch = 0; ch < N; ch++) check($sformatf("rise_ch%0d", ch), rise_edge[ch] - k, onv[ch]);
      en = '0;
      k  = cyc + 1;
      run(65540);
      for (int ch = 0; ch < N; ch++) begin
         check($sformatf("fall_ch%0d", ch), fall_edge[ch] - k, offv[ch]);
         check($sformatf("busy_len_ch%0d", ch), busy_cnt[ch], onv[ch] + offv[ch]);
      end

      // Short-pulse rejection on channel 1
      phase = "short_pulse";
      on_d[1*W +: W]  = W'(10);
      off_d[1*W +: W] = W'(0);
      clear_marks();
      en[1] = 1'b1;
      run(9);
      en[1] = 1'b0;
      run(3);
      check("short_no_rise", rise_edge[1], -1);
      check("short_busy_len", busy_cnt[1], 9);
      clear_marks();
      en[1] = 1'b1;
      k = cyc + 1;
      run(11);
      en[1] = 1'b0;
      run(3);
      check("pulse_rise", rise_edge[1] - k, 10);
      check("pulse_fall", fall_edge[1] - k, 11);

      // Gap rejection on channel 2
      phase = "gap";
      on_d[2*W +: W]  = W'(0);
      off_d[2*W +: W] = W'(4);
      en[2] = 1'b1;
      run(2);
      clear_marks();
      en[2] = 1'b0;
      run(3);
      en[2] = 1'b1;
      run(3);
      check("gap_no_fall", fall_edge[2], -1);
      check("gap_de_high", 32'(de[2]), 32'(1));
      check("gap_back_on", 32'(busy[2]), 32'(0));
      check("gap_busy_len", busy_cnt[2], 3);
      en[2] = 1'b0;
      run(5);

      // Delay changed mid-count on channel 3
      phase = "dly_change";
      on_d[3*W +: W]  = W'(20);
      off_d[3*W +: W] = W'(0);
      clear_marks();
      en[3] = 1'b1;
      k = cyc + 1;
      run(2);
      on_d[3*W +: W] = W'(3);
      run(20);
      check("change_rise_old", rise_edge[3] - k, 20);
      en[3] = 1'b0;
      run(2);
      clear_marks();
      en[3] = 1'b1;
      k = cyc + 1;
      run(5);
      check("change_rise_new", rise_edge[3] - k, 3);
      en[3] = 1'b0;
      run(2);

      // Random enables and delays on all channels
      phase = "random";
      for (int i = 0; i < 10000; i++) begin
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(0, 7) == 0) en[ch] = ~en[ch];
            if ($urandom_range(0, 3) == 0) on_d[ch*W +: W]  = W'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) off_d[ch*W +: W] = W'($urandom_range(0, 12));
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
